// File: rtl/screen_uart_pkg.sv
// Shared constants and state encoding for the screen UART receive path.
// Build option: SCREEN_RX_PARITY_EN selects 8E1 framing in screen_rx_module.
package screen_uart_pkg;

  localparam int   BAUD_RATE_DIV   = 5208;
  localparam int   FRAME_DATA_BITS = 8;
  localparam logic IDLE_LEVEL      = 1'b1;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Both flops reset to RST_VAL so the output never shows a false edge after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/screen_rx_module.sv
// UART receiver (8N1, LSB first) with valid/ready byte output, framing and overrun flags.
// Build option: SCREEN_RX_PARITY_EN switches to 8E1 and enables parityErr.
module screen_rx_module
  import screen_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_RATE_DIV
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxIn,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic       frameErr,
  output logic       overrun,
  output logic       parityErr
);

  localparam int              CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   DIV_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]   DIV_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [2:0]      LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  rx_state_t     state;
  logic          rxS;
  logic [CW-1:0] divCount;
  logic [2:0]    bitCount;
  logic [7:0]    shreg;
  logic          bitTick;
  logic          halfTick;
  logic          stopGood;
  logic          deliver;
  logic          parBad;

  sync_2ff #(
    .RST_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxIn),
    .q       (rxS)
  );

  assign bitTick  = (divCount == DIV_LAST);
  assign halfTick = (divCount == DIV_HALF);
  // A well-framed byte is only handed over when its parity (if any) also checked out.
  assign stopGood = (state == STOP) && bitTick && (rxS == STOP_BIT) && !parBad;
  assign deliver  = stopGood && (!rxValid || rxReady);

`ifdef SCREEN_RX_PARITY_EN
  logic parFlag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parFlag   <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      parityErr <= (state == STOP) && bitTick && (rxS == STOP_BIT) && parFlag;
      if (state == PARITY && bitTick) begin
        parFlag <= rxS ^ (^shreg);
      end
    end
  end

  assign parBad = parFlag;
`else
  assign parBad    = 1'b0;
  assign parityErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      divCount <= '0;
      bitCount <= '0;
      shreg    <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      frameErr <= (state == STOP) && bitTick && (rxS != STOP_BIT);
      overrun  <= stopGood && rxValid && !rxReady;

      if (deliver) begin
        rxData  <= shreg;
        rxValid <= 1'b1;
      end else if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end

      case (state)
        IDLE: begin
          divCount <= '0;
          if (rxS == START_BIT) begin
            state <= START;
          end
        end
        START: begin
          // Re-check the line at mid start bit so short glitches are dropped silently.
          if (halfTick) begin
            divCount <= '0;
            bitCount <= '0;
            state    <= (rxS == START_BIT) ? DATA : IDLE;
          end else begin
            divCount <= divCount + 1'b1;
          end
        end
        DATA: begin
          if (bitTick) begin
            divCount <= '0;
            shreg    <= {rxS, shreg[7:1]};
            bitCount <= bitCount + 1'b1;
            if (bitCount == LAST_BIT) begin
`ifdef SCREEN_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            divCount <= divCount + 1'b1;
          end
        end
`ifdef SCREEN_RX_PARITY_EN
        PARITY: begin
          if (bitTick) begin
            divCount <= '0;
            state    <= STOP;
          end else begin
            divCount <= divCount + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bitTick) begin
            divCount <= '0;
            state    <= (rxS == STOP_BIT) ? IDLE : BREAK;
          end else begin
            divCount <= divCount + 1'b1;
          end
        end
        BREAK: begin
          // A line held low after a bad stop bit must not be read as a new start bit.
          divCount <= '0;
          if (rxS == IDLE_LEVEL) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          divCount <= '0;
        end
      endcase
    end
  end

endmodule
